// File: rtl/alu_pkg.sv
// Shared opcode and FSM state encodings for the shared-ALU arbiter.
package alu_pkg;

   localparam logic [1:0] OP_ADD = 2'b00;
   localparam logic [1:0] OP_SUB = 2'b01;
   localparam logic [1:0] OP_AND = 2'b10;
   localparam logic [1:0] OP_OR  = 2'b11;

   typedef enum logic [1:0] {
      S_IDLE = 2'b00,
      S_EXEC = 2'b01,
      S_DONE = 2'b10
   } state_t;

endpackage

// File: rtl/alu_reg_core.sv
// N-bit ALU with registered result and carry, loaded when en is high.
module alu_reg_core
   import alu_pkg::*;
#(
   parameter int unsigned N = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         en,
   input  logic [1:0]   op,
   input  logic [N-1:0] a,
   input  logic [N-1:0] b,
   output logic [N-1:0] result,
   output logic         carry
);

   logic [N:0] alu_c;

   // Arithmetic at N+1 bits: top bit is carry-out for ADD, borrow for SUB.
   always_comb begin
      alu_c = '0;
      case (op)
         OP_ADD:  alu_c = {1'b0, a} + {1'b0, b};
         OP_SUB:  alu_c = {1'b0, a} - {1'b0, b};
         OP_AND:  alu_c = {1'b0, a & b};
         default: alu_c = {1'b0, a | b};
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         result <= '0;
         carry  <= 1'b0;
      end else if (en) begin
         result <= alu_c[N-1:0];
         carry  <= alu_c[N];
      end
   end

endmodule

// File: rtl/alu_share_arbiter.sv
// Round-robin arbiter sharing one registered ALU between two requesters.
module alu_share_arbiter
   import alu_pkg::*;
#(
   parameter int unsigned N = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         req0,
   input  logic [1:0]   op0,
   input  logic [N-1:0] a0,
   input  logic [N-1:0] b0,
   input  logic         req1,
   input  logic [1:0]   op1,
   input  logic [N-1:0] a1,
   input  logic [N-1:0] b1,
   output logic [1:0]   grant,
   output logic         done0,
   output logic         done1,
   output logic [N-1:0] result,
   output logic         carry,
   output logic         busy
);

   state_t       state, state_next;
   logic         ptr, ptr_next;
   logic [1:0]   grant_next;
   logic         done0_next, done1_next, busy_next;
   logic [1:0]   op_l, op_next;
   logic [N-1:0] a_l, a_next, b_l, b_next;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= S_IDLE;
         ptr   <= 1'b0;
         grant <= 2'b00;
         done0 <= 1'b0;
         done1 <= 1'b0;
         busy  <= 1'b0;
         op_l  <= OP_ADD;
         a_l   <= '0;
         b_l   <= '0;
      end else begin
         state <= state_next;
         ptr   <= ptr_next;
         grant <= grant_next;
         done0 <= done0_next;
         done1 <= done1_next;
         busy  <= busy_next;
         op_l  <= op_next;
         a_l   <= a_next;
         b_l   <= b_next;
      end
   end

   always_comb begin
      state_next = state;
      ptr_next   = ptr;
      grant_next = grant;
      done0_next = 1'b0;
      done1_next = 1'b0;
      op_next    = op_l;
      a_next     = a_l;
      b_next     = b_l;
      case (state)
         S_IDLE: begin
            // Requester 0 wins when alone or when the pointer favours it.
            if (req0 && (!req1 || !ptr)) begin
               grant_next = 2'b01;
               op_next    = op0;
               a_next     = a0;
               b_next     = b0;
               state_next = S_EXEC;
            end else if (req1) begin
               grant_next = 2'b10;
               op_next    = op1;
               a_next     = a1;
               b_next     = b1;
               state_next = S_EXEC;
            end
         end
         S_EXEC: begin
            done0_next = grant[0];
            done1_next = grant[1];
            state_next = S_DONE;
         end
         S_DONE: begin
            // Hand priority to whichever requester was not just served.
            ptr_next   = grant[0];
            grant_next = 2'b00;
            state_next = S_IDLE;
         end
         default: begin
            grant_next = 2'b00;
            state_next = S_IDLE;
         end
      endcase
      busy_next = (state_next != S_IDLE);
   end

   alu_reg_core #(.N(N)) u_core (
      .clk    (clk),
      .rst    (rst),
      .en     (state == S_EXEC),
      .op     (op_l),
      .a      (a_l),
      .b      (b_l),
      .result (result),
      .carry  (carry)
   );

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Randomized and directed self-checking bench for alu_share_arbiter.
module tb_alu_share_arbiter;

   localparam int unsigned N = 4;

   logic         clk = 1'b0;
   logic         rst;
   logic         req0, req1;
   logic [1:0]   op0, op1;
   logic [N-1:0] a0, b0, a1, b1;
   logic [1:0]   grant;
   logic         done0, done1, carry, busy;
   logic [N-1:0] result;

   logic         rq [2];
   logic [1:0]   opv [2];
   logic [N-1:0] av [2];
   logic [N-1:0] bv [2];

   assign req0 = rq[0];
   assign req1 = rq[1];
   assign op0  = opv[0];
   assign op1  = opv[1];
   assign a0   = av[0];
   assign a1   = av[1];
   assign b0   = bv[0];
   assign b1   = bv[1];

   always #5 clk = ~clk;

   alu_share_arbiter #(.N(N)) dut (
      .clk(clk), .rst(rst),
      .req0(req0), .op0(op0), .a0(a0), .b0(b0),
      .req1(req1), .op1(op1), .a1(a1), .b1(b1),
      .grant(grant), .done0(done0), .done1(done1),
      .result(result), .carry(carry), .busy(busy)
   );

   int pass_cnt  = 0;
   int total_cnt = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total_cnt++;
      if (got === exp) pass_cnt++;
      else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
   endtask

   // Transaction-level model: an operation sampled at edge s completes at s+1
   // and frees the ALU so the next sample happens at s+3.
   int cyc       = 0;
   bit inflight  = 0;
   int s_edge    = 0;
   int win       = 0;
   int ptr       = 0;
   int lop, la, lb;
   int exp_res   = 0;
   int exp_carry = 0;
   int last_done = -1;
   int drop_at [2] = '{-1, -1};
   bit auto_mode = 0;
   bit keep_high = 0;

   function automatic void ref_alu(input int op, input int a, input int b,
                                   output int r, output int c);
      int m;
      m = 1 << N;
      case (op)
         0:       begin r = (a + b) % m;     c = ((a + b) >= m) ? 1 : 0; end
         1:       begin r = (a - b + m) % m; c = (a < b) ? 1 : 0;        end
         2:       begin r = a & b;           c = 0;                      end
         default: begin r = a | b;           c = 0;                      end
      endcase
   endfunction

   task automatic model_edge();
      cyc++;
      last_done = -1;
      if (rst) begin
         inflight = 0; ptr = 0; exp_res = 0; exp_carry = 0;
      end else if (!inflight) begin
         if (rq[0] || rq[1]) begin
            win = (rq[0] && rq[1]) ? ptr : (rq[0] ? 0 : 1);
            lop = int'(opv[win]); la = int'(av[win]); lb = int'(bv[win]);
            s_edge = cyc; inflight = 1;
         end
      end else if (cyc == s_edge + 1) begin
         ref_alu(lop, la, lb, exp_res, exp_carry);
         last_done = win;
         drop_at[win] = cyc + 1;
      end else if (cyc == s_edge + 2) begin
         inflight = 0;
         ptr = (win == 0) ? 1 : 0;
      end
   endtask

   task automatic check_outputs();
      int eg;
      eg = inflight ? ((win == 0) ? 1 : 2) : 0;
      check("grant",  32'(grant),  32'(eg));
      check("busy",   32'(busy),   32'(inflight));
      check("done0",  32'(done0),  32'(last_done == 0));
      check("done1",  32'(done1),  32'(last_done == 1));
      check("result", 32'(result), 32'(exp_res));
      check("carry",  32'(carry),  32'(exp_carry));
   endtask

   task automatic drive();
      for (int i = 0; i < 2; i++) begin
         if (!keep_high && rq[i] && drop_at[i] == cyc) begin
            rq[i] = 1'b0;
         end else if (auto_mode && !rq[i] && $urandom_range(2) == 0) begin
            rq[i]  = 1'b1;
            opv[i] = 2'($urandom);
            av[i]  = N'($urandom);
            bv[i]  = N'($urandom);
         end else if (auto_mode && rq[i] && inflight && win == i && $urandom_range(3) == 0) begin
            // Operands changed after grant must not reach the in-flight op.
            opv[i] = 2'($urandom);
            av[i]  = N'($urandom);
            bv[i]  = N'($urandom);
         end
      end
   endtask

   task automatic step();
      @(posedge clk);
      model_edge();
      #1;
      check_outputs();
      drive();
   endtask

   task automatic do_reset();
      rst = 1'b1;
      step();
      #4 rst = 1'b0;
   endtask

   task automatic run_op(input int i, input logic [1:0] op, input logic [N-1:0] a,
                         input logic [N-1:0] b, input int er, input int ec, input string tag);
      bit got;
      got = 0;
      rq[i] = 1'b1; opv[i] = op; av[i] = a; bv[i] = b;
      for (int k = 0; k < 12; k++) begin
         step();
         if (last_done == i) begin
            check({tag, "_res"},   32'(result), 32'(er));
            check({tag, "_carry"}, 32'(carry),  32'(ec));
            got = 1;
         end
         if (got && !inflight) break;
      end
      if (!got) check({tag, "_timeout"}, 32'd0, 32'd1);
   endtask

   initial begin
      int seq_w [$];
      int seq_r [$];
      rst = 1'b1;
      for (int i = 0; i < 2; i++) begin
         rq[i] = 1'b1; opv[i] = 2'b00; av[i] = 4'h3; bv[i] = 4'h5;
      end
      #1;
      step();
      step();
      check("rst_grant", 32'(grant), 32'd0);
      check("rst_busy",  32'(busy),  32'd0);
      rq[0] = 1'b0; rq[1] = 1'b0;
      #4 rst = 1'b0;

      run_op(0, 2'b00, 4'b0010, 4'b0100, 4'b0110, 0, "add0");
      run_op(1, 2'b00, 4'b1111, 4'b0001, 4'b0000, 1, "add_wrap");
      run_op(1, 2'b01, 4'b0010, 4'b0100, 4'b1110, 1, "sub_borrow");
      run_op(0, 2'b10, 4'b1100, 4'b1010, 4'b1000, 0, "and");
      run_op(0, 2'b11, 4'b1100, 4'b1010, 4'b1110, 0, "or");

      // Fairness with both requests held continuously from reset.
      do_reset();
      keep_high = 1;
      rq[0] = 1'b1; opv[0] = 2'b00; av[0] = 4'b0001; bv[0] = 4'b0001;
      rq[1] = 1'b1; opv[1] = 2'b00; av[1] = 4'b0011; bv[1] = 4'b0011;
      for (int k = 0; k < 20 && seq_w.size() < 3; k++) begin
         step();
         if (last_done >= 0) begin
            seq_w.push_back(last_done);
            seq_r.push_back(int'(result));
            check("fair_no_overlap", 32'(done0 && done1), 32'd0);
         end
      end
      if (seq_w.size() < 3) check("fair_timeout", 32'(seq_w.size()), 32'd3);
      else begin
         check("fair_w0", 32'(seq_w[0]), 32'd0);
         check("fair_w1", 32'(seq_w[1]), 32'd1);
         check("fair_w2", 32'(seq_w[2]), 32'd0);
         check("fair_r0", 32'(seq_r[0]), 32'd2);
         check("fair_r1", 32'(seq_r[1]), 32'd6);
         check("fair_r2", 32'(seq_r[2]), 32'd2);
      end
      step();
      keep_high = 0;
      rq[0] = 1'b0; rq[1] = 1'b0;
      step();
      step();

      // Reset asserted while requester 0's SUB is executing.
      rq[0] = 1'b1; opv[0] = 2'b01; av[0] = 4'b0101; bv[0] = 4'b0001;
      step();
      check("pre_rst_grant", 32'(grant), 32'd1);
      #3 rst = 1'b1;
      #1;
      check("async_grant",  32'(grant),  32'd0);
      check("async_busy",   32'(busy),   32'd0);
      check("async_done0",  32'(done0),  32'd0);
      check("async_result", 32'(result), 32'd0);
      check("async_carry",  32'(carry),  32'd0);
      step();
      #4 rst = 1'b0;
      run_op(0, 2'b01, 4'b0101, 4'b0001, 4'b0100, 0, "reissue");

      auto_mode = 1;
      for (int k = 0; k < 600; k++) step();
      auto_mode = 0;
      for (int k = 0; k < 8; k++) step();

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
